// File: rtl/sci_uart.sv
// rtl/sci_uart.sv - 8N1 serial port with a CPU-visible status/control/data register set
// Define SCI_RXFIFO_EN to replace the single receive register with a 4-entry FIFO.
module sci_uart #(
  parameter int DIV = 5208
) (
  input  logic       clk50,
  input  logic       resetin,
  input  logic [7:0] dbus,
  output logic [7:0] sciout,
  input  logic       IOaddr,
  input  logic [2:0] addr,
  input  logic       read,
  input  logic       write,
  input  logic       rxd,
  output logic       txd
);
  localparam logic [15:0] BIT_END  = 16'(DIV - 1);
  localparam logic [15:0] HALF_END = 16'(DIV / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      tx_st, rx_st;
  logic        wr_q, rd7_q, wr_pulse, rd_done;
  logic        te, re, tdre, tc, rdrf, ovr, fe;
  logic [7:0]  tdr, tx_sh, rx_sh, rdata;
  logic [15:0] tx_cnt, rx_cnt;
  logic [2:0]  tx_bit, rx_bit;
  logic        rs1, rs2, rs3;
  logic        rx_push, push_ok, pop_ok;

  assign wr_pulse = IOaddr & write & ~wr_q;
  // Read side effects wait for the strobe to drop so the CPU sees the byte first.
  assign rd_done  = rd7_q & ~(IOaddr & read);
  assign rx_push  = re && (rx_st == S_STOP) && (rx_cnt == BIT_END);

  always_ff @(posedge clk50 or negedge resetin) begin
    if (!resetin) begin
      wr_q <= 1'b0; rd7_q <= 1'b0;
      te <= 1'b1; re <= 1'b1; tdre <= 1'b1; tc <= 1'b1;
      tdr <= 8'h00; tx_sh <= 8'h00; tx_st <= S_IDLE;
      tx_cnt <= 16'd0; tx_bit <= 3'd0; txd <= 1'b1;
    end else begin
      wr_q  <= IOaddr & write;
      rd7_q <= IOaddr & read & (addr == 3'd7);
      case (tx_st)
        S_IDLE: if (te && !tdre) begin
          tx_sh <= tdr; txd <= 1'b0; tdre <= 1'b1; tx_cnt <= 16'd0; tx_st <= S_START;
        end
        S_START: if (tx_cnt == BIT_END) begin
          tx_cnt <= 16'd0; tx_bit <= 3'd0; txd <= tx_sh[0]; tx_st <= S_DATA;
        end else tx_cnt <= tx_cnt + 16'd1;
        S_DATA: if (tx_cnt == BIT_END) begin
          tx_cnt <= 16'd0;
          if (tx_bit == 3'd7) begin
            txd <= 1'b1; tx_st <= S_STOP;
          end else begin
            txd <= tx_sh[1]; tx_sh <= {1'b0, tx_sh[7:1]}; tx_bit <= tx_bit + 3'd1;
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        S_STOP: if (tx_cnt == BIT_END) begin
          tx_cnt <= 16'd0;
          // Reloading straight from STOP keeps consecutive frames gap-free.
          if (te && !tdre) begin
            tx_sh <= tdr; txd <= 1'b0; tdre <= 1'b1; tx_st <= S_START;
          end else begin
            tx_st <= S_IDLE;
            if (tdre) tc <= 1'b1;
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        default: tx_st <= S_IDLE;
      endcase
      if (wr_pulse) begin
        if (addr == 3'd5) begin
          te <= dbus[3]; re <= dbus[2];
        end else if (addr == 3'd7 && tdre) begin
          tdr <= dbus; tdre <= 1'b0; tc <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk50 or negedge resetin) begin
    if (!resetin) begin
      rs1 <= 1'b1; rs2 <= 1'b1; rs3 <= 1'b1;
      rx_st <= S_IDLE; rx_cnt <= 16'd0; rx_bit <= 3'd0; rx_sh <= 8'h00;
    end else begin
      rs1 <= rxd; rs2 <= rs1; rs3 <= rs2;
      if (!re) rx_st <= S_IDLE;
      else case (rx_st)
        S_IDLE: if (rs3 && !rs2) begin
          rx_cnt <= 16'd0; rx_st <= S_START;
        end
        S_START: if (rx_cnt == HALF_END) begin
          rx_cnt <= 16'd0; rx_bit <= 3'd0;
          rx_st  <= rs2 ? S_IDLE : S_DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        S_DATA: if (rx_cnt == BIT_END) begin
          rx_cnt <= 16'd0; rx_sh <= {rs2, rx_sh[7:1]}; rx_bit <= rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_st <= S_STOP;
        end else rx_cnt <= rx_cnt + 16'd1;
        S_STOP: if (rx_cnt == BIT_END) rx_st <= S_IDLE;
                else rx_cnt <= rx_cnt + 16'd1;
        default: rx_st <= S_IDLE;
      endcase
    end
  end

`ifdef SCI_RXFIFO_EN
  logic [7:0] rmem [4];
  logic [1:0] wp, rp;
  logic [2:0] rcnt;

  assign pop_ok  = rd_done && (rcnt != 3'd0);
  assign push_ok = rx_push && ((rcnt != 3'd4) || pop_ok);
  assign rdrf    = (rcnt != 3'd0);
  assign rdata   = rmem[rp];

  always_ff @(posedge clk50)
    if (push_ok) rmem[wp] <= rx_sh;

  always_ff @(posedge clk50 or negedge resetin) begin
    if (!resetin) begin
      wp <= 2'd0; rp <= 2'd0; rcnt <= 3'd0; ovr <= 1'b0; fe <= 1'b0;
    end else begin
      if (rd_done) begin ovr <= 1'b0; fe <= 1'b0; end
      if (pop_ok) rp <= rp + 2'd1;
      if (push_ok) wp <= wp + 2'd1;
      if (rx_push && !push_ok) ovr <= 1'b1;
      if (rx_push && !rs2) fe <= 1'b1;
      rcnt <= rcnt + {2'b0, push_ok} - {2'b0, pop_ok};
    end
  end
`else
  logic [7:0] rbuf;
  logic       rfull;

  assign pop_ok  = rd_done && rfull;
  assign push_ok = rx_push && (!rfull || pop_ok);
  assign rdrf    = rfull;
  assign rdata   = rbuf;

  always_ff @(posedge clk50 or negedge resetin) begin
    if (!resetin) begin
      rbuf <= 8'h00; rfull <= 1'b0; ovr <= 1'b0; fe <= 1'b0;
    end else begin
      if (rd_done) begin ovr <= 1'b0; fe <= 1'b0; end
      if (push_ok) begin
        rbuf <= rx_sh; rfull <= 1'b1;
      end else if (pop_ok) rfull <= 1'b0;
      if (rx_push && !push_ok) ovr <= 1'b1;
      if (rx_push && !rs2) fe <= 1'b1;
    end
  end
`endif

  always_comb begin
    sciout = 8'h00;
    if (IOaddr)
      case (addr)
        3'd4:    sciout = {tdre, tc, rdrf, 1'b0, ovr, 1'b0, fe, 1'b0};
        3'd5:    sciout = {4'b0000, te, re, 2'b00};
        3'd7:    sciout = rdata;
        default: sciout = 8'h00;
      endcase
  end
endmodule

// File: tb/tb_sci_uart.sv
// tb/tb_sci_uart.sv - directed bench for sci_uart with a frame-level tx/rx model
module tb_sci_uart;
  localparam int DIV = 16;
  localparam int FR  = 10 * DIV;
`ifdef SCI_RXFIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic       clk50 = 1'b0;
  logic       resetin = 1'b0;
  logic [7:0] dbus = 8'h00;
  logic [7:0] sciout;
  logic       IOaddr = 1'b1;
  logic [2:0] addr = 3'd4;
  logic       read = 1'b0;
  logic       write = 1'b0;
  logic       rxd = 1'b1;
  logic       txd;

  sci_uart #(.DIV(DIV)) dut (
    .clk50(clk50), .resetin(resetin), .dbus(dbus), .sciout(sciout),
    .IOaddr(IOaddr), .addr(addr), .read(read), .write(write),
    .rxd(rxd), .txd(txd)
  );

  always #10 clk50 = ~clk50;

  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;
  logic rx_quiet = 1'b1;

  int f_e[$];
  int f_s[$];
  logic [7:0] f_b[$];
  logic [7:0] rq[$];
  logic m_or = 1'b0;
  logic m_fe = 1'b0;

  function automatic void chk8(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endfunction

  // Frame k starts one edge after its write, or when the previous frame ends.
  function automatic void model_write(int e, logic [7:0] d);
    int s;
    if (f_s.size() == 0 || f_s[f_s.size()-1] < e) begin
      s = e + 1;
      if (f_s.size() != 0 && f_s[f_s.size()-1] + FR > s) s = f_s[f_s.size()-1] + FR;
      f_e.push_back(e); f_s.push_back(s); f_b.push_back(d);
    end
  endfunction

  function automatic logic exp_txd(int n);
    logic [7:0] b;
    int k;
    for (int i = 0; i < f_s.size(); i++)
      if (n >= f_s[i] && n < f_s[i] + FR) begin
        k = (n - f_s[i]) / DIV;
        b = f_b[i];
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
      end
    return 1'b1;
  endfunction

  function automatic void exp_tx_flags(int n, output logic tdre, output logic tc);
    tdre = 1'b1; tc = 1'b1;
    for (int i = 0; i < f_e.size(); i++)
      if (f_e[i] <= n) begin
        tdre = (n >= f_s[i]);
        tc   = (n >= f_s[i] + FR);
      end
  endfunction

  logic       ce_tdre, ce_tc;
  logic [7:0] ce_stat;
  always @(posedge clk50) begin
    #1;
    if (chk_on) begin
      chk8("txd", {7'b0, txd}, {7'b0, exp_txd(cyc)});
      if (IOaddr && addr == 3'd4) begin
        exp_tx_flags(cyc, ce_tdre, ce_tc);
        ce_stat = {ce_tdre, ce_tc, rq.size() != 0, 1'b0, m_or, 1'b0, m_fe, 1'b0};
        if (rx_quiet) chk8("scis1_model", sciout, ce_stat);
        else chk8("scis1_tx_model", {sciout[7:6], 6'b0}, {ce_stat[7:6], 6'b0});
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d, output int e);
    @(negedge clk50);
    addr = a; dbus = d; write = 1'b1;
    e = cyc + 1;
    if (a == 3'd7) model_write(e, d);
    repeat (4) @(negedge clk50);
    write = 1'b0; addr = 3'd4;
    @(negedge clk50);
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string nm);
    @(negedge clk50);
    addr = a; read = 1'b1;
    repeat (3) @(negedge clk50);
    chk8(nm, sciout, exp);
    read = 1'b0; addr = 3'd4;
    if (a == 3'd7) begin
      if (rq.size() != 0) void'(rq.pop_front());
      m_or = 1'b0; m_fe = 1'b0;
    end
    repeat (2) @(negedge clk50);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    rx_quiet = 1'b0;
    @(negedge clk50);
    rxd = 1'b0;
    repeat (DIV) @(negedge clk50);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk50);
    end
    rxd = stop;
    repeat (DIV) @(negedge clk50);
    rxd = 1'b1;
    repeat (4) @(negedge clk50);
    if (rq.size() < CAP) rq.push_back(b); else m_or = 1'b1;
    if (!stop) m_fe = 1'b1;
    rx_quiet = 1'b1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk50);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e1, e2, e3, s1;
    logic [9:0] pat;
    repeat (3) @(negedge clk50);
    chk8("txd_in_reset", {7'b0, txd}, 8'h01);
    resetin = 1'b1;
    repeat (2) @(negedge clk50);
    chk_on = 1'b1;

    rd(3'd4, 8'hC0, "reset_scis1");
    rd(3'd5, 8'h0C, "reset_scic2");
    rd(3'd6, 8'h00, "reserved_read");
    rd(3'd0, 8'h00, "offset0_read");
    @(negedge clk50);
    IOaddr = 1'b0; addr = 3'd5;
    @(negedge clk50);
    chk8("no_select", sciout, 8'h00);
    IOaddr = 1'b1; addr = 3'd4;

    wr(3'd5, 8'h00, e1); rd(3'd5, 8'h00, "scic2_clear");
    wr(3'd5, 8'hFF, e1); rd(3'd5, 8'h0C, "scic2_mask");
    wr(3'd6, 8'hFF, e1); rd(3'd6, 8'h00, "reserved_write");
    wr(3'd4, 8'h00, e1); rd(3'd4, 8'hC0, "status_write_ignored");

    // Single 0x55 frame.
    wr(3'd7, 8'h55, e1);
    s1 = e1 + 1;
    pat = 10'b1010101010;
    for (int k = 0; k < 10; k++) begin
      wait_to(s1 + k * DIV + 8);
      chk8("tx55_bit", {7'b0, txd}, {7'b0, pat[k]});
    end
    wait_to(s1 + FR + 2);
    chk8("tx55_done", sciout, 8'hC0);

    // 0x41 and 0x42 back to back; 0x43 arrives while TDR is full.
    wr(3'd7, 8'h41, e1);
    s1 = e1 + 1;
    repeat (20) @(negedge clk50);
    wr(3'd7, 8'h42, e2);
    wr(3'd7, 8'h43, e3);
    wait_to(s1 + FR - 1);
    chk8("b2b_stop", {7'b0, txd}, 8'h01);
    wait_to(s1 + FR);
    chk8("b2b_start", {7'b0, txd}, 8'h00);
    wait_to(s1 + FR + 2 * DIV + 8);
    chk8("b2b_d1", {7'b0, txd}, 8'h01);
    wait_to(s1 + 2 * FR + DIV + 8);
    chk8("third_dropped", {7'b0, txd}, 8'h01);
    chk8("idle_status", sciout, 8'hC0);

    // Receive path.
    send_rx(8'hA3, 1'b1);
    rd(3'd4, 8'hE0, "rx_a3_status");
    rd(3'd7, 8'hA3, "rx_a3_data");
    rd(3'd4, 8'hC0, "rx_a3_after");

    for (int i = 0; i <= CAP; i++) send_rx(8'(8'h11 * (i + 1)), 1'b1);
    rd(3'd4, 8'hE8, "ovr_status");
    rd(3'd7, 8'h11, "ovr_first");
    while (rq.size() != 0) rd(3'd7, rq[0], "ovr_drain");
    rd(3'd4, 8'hC0, "ovr_after");

    send_rx(8'h5A, 1'b0);
    rd(3'd4, 8'hE2, "fe_status");
    rd(3'd7, 8'h5A, "fe_data");
    rd(3'd4, 8'hC0, "fe_after");

    @(negedge clk50);
    rxd = 1'b0;
    repeat (3) @(negedge clk50);
    rxd = 1'b1;
    repeat (40) @(negedge clk50);
    chk8("glitch_status", sciout, 8'hC0);

    // Reset in the middle of a 0x00 frame.
    wr(3'd7, 8'h00, e1);
    s1 = e1 + 1;
    wait_to(s1 + 3 * DIV + 8);
    chk8("pre_reset_txd", {7'b0, txd}, 8'h00);
    chk_on = 1'b0;
    #3 resetin = 1'b0;
    #1 chk8("reset_async_txd", {7'b0, txd}, 8'h01);
    f_e.delete(); f_s.delete(); f_b.delete(); rq.delete();
    m_or = 1'b0; m_fe = 1'b0;
    repeat (3) @(negedge clk50);
    resetin = 1'b1;
    repeat (2) @(negedge clk50);
    chk_on = 1'b1;
    rd(3'd4, 8'hC0, "post_reset_scis1");
    rd(3'd5, 8'h0C, "post_reset_scic2");
    repeat (4) @(negedge clk50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
